// File: rtl/ddc_pkg.sv
// ddc_pkg -- shared constants and types for the 1-bit-RF digital down-converter.
//
// Contents:
//   PHASE_W / ACC_W   NCO and CIC datapath widths (20 bits)
//   GAIN_W            width of the output gain select
//   CIC_N             number of integrator/comb stages
//   DECIM_LOG2        log2 of the decimation ratio (R = 64)
//   OUT_W             baseband output sample width
//   BASE_SHIFT        right shift applied at gain = 0
//   acc_t             signed CIC datapath word
//   saturate()        clamps a CIC word to the signed OUT_W range
package ddc_pkg;

  localparam int PHASE_W    = 20;
  localparam int GAIN_W     = 3;
  localparam int CIC_N      = 3;
  localparam int DECIM_LOG2 = 6;
  localparam int ACC_W      = 20;
  localparam int OUT_W      = 8;
  localparam int BASE_SHIFT = 12;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t OUT_MAX = acc_t'((1 <<< (OUT_W - 1)) - 1);
  localparam acc_t OUT_MIN = acc_t'(-(1 <<< (OUT_W - 1)));

  function automatic logic [OUT_W-1:0] saturate(input acc_t v);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/cic_chain.sv
// cic_chain -- one channel of the decimating CIC filter (3 integrators, 3 combs,
// gain shift and saturation).
//
// Ports:
//   CLK         system clock
//   RSTb        synchronous active-low reset
//   sample_pos  mixer output for this cycle: 1 = +1, 0 = -1
//   dump        high in the last cycle of a decimation frame
//   gain        shadowed gain select; result is shifted right by BASE_SHIFT - gain
//   result      signed, saturated output sample, updated the cycle after dump
module cic_chain
  import ddc_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              sample_pos,
  input  logic              dump,
  input  logic [GAIN_W-1:0] gain,
  output logic [OUT_W-1:0]  result
);

  acc_t       x;
  acc_t       integ      [CIC_N];
  acc_t       integ_next [CIC_N];
  acc_t       comb_dly   [CIC_N];
  acc_t       comb_val   [CIC_N];
  acc_t       shifted;
  logic [3:0] shamt;

  // The integrators are a true cascade: each stage adds the *new* value of the
  // stage before it, so the frame-end dump already contains this cycle's sample.
  // NOTE: every always_comb output gets a value on every path (here each element
  // unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    x = sample_pos ? 20'sd1 : -20'sd1;
    integ_next[0] = integ[0] + x;
    for (int s = 1; s < CIC_N; s++) begin
      integ_next[s] = integ[s] + integ_next[s-1];
    end
    comb_val[0] = integ_next[CIC_N-1] - comb_dly[0];
    for (int s = 1; s < CIC_N; s++) begin
      comb_val[s] = comb_val[s-1] - comb_dly[s];
    end
    shamt   = 4'(BASE_SHIFT) - 4'(gain);
    shifted = comb_val[CIC_N-1] >>> shamt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the cascade does not ripple within a cycle.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      // NOTE: the comb delay words are cleared as well as the integrators; a
      // stale delay word would corrupt the first frames after reset.
      for (int s = 0; s < CIC_N; s++) begin
        integ[s]    <= '0;
        comb_dly[s] <= '0;
      end
      result <= '0;
    end else begin
      for (int s = 0; s < CIC_N; s++) begin
        integ[s] <= integ_next[s];
      end
      if (dump) begin
        comb_dly[0] <= integ_next[CIC_N-1];
        for (int s = 1; s < CIC_N; s++) begin
          comb_dly[s] <= comb_val[s-1];
        end
        result <= saturate(shifted);
      end
    end
  end

endmodule

// File: rtl/ddc_cic.sv
// ddc_cic -- 1-bit RF digital down-converter: NCO, quadrature mixer and two
// CIC decimators (R = 64, N = 3).
//
// Ports:
//   CLK        system clock, one RF sample per rising edge
//   RSTb       synchronous active-low reset
//   rf_in      comparator sample, 1 = +1, 0 = -1
//   phase_inc  NCO tuning word (shadowed at frame boundaries)
//   gain       output gain select (shadowed at frame boundaries)
//   out_i      signed in-phase baseband sample, held between strobes
//   out_q      signed quadrature baseband sample, held between strobes
//   out_valid  one-cycle strobe, once every 64 cycles
module ddc_cic
  import ddc_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               rf_in,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [GAIN_W-1:0]  gain,
  output logic [OUT_W-1:0]   out_i,
  output logic [OUT_W-1:0]   out_q,
  output logic               out_valid
);

  logic [PHASE_W-1:0]    acc;
  logic [PHASE_W-1:0]    phase_inc_s;
  logic [GAIN_W-1:0]     gain_s;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  frame_end;
  logic                  lo_i_neg;
  logic                  lo_q_neg;
  logic                  mix_i_pos;
  logic                  mix_q_pos;

  assign frame_end = (cnt == '1);

  // Square-wave LO: I is the quadrant sign of cos, Q the sign of sin.
  assign lo_i_neg = acc[PHASE_W-1] ^ acc[PHASE_W-2];
  assign lo_q_neg = acc[PHASE_W-1];

  // rf_in XNOR (NOT lo_neg) reduces to rf_in XOR lo_neg.
  assign mix_i_pos = rf_in ^ lo_i_neg;
  assign mix_q_pos = rf_in ^ lo_q_neg;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc + phase_inc_s;
      cnt       <= cnt + DECIM_LOG2'(1);
      out_valid <= frame_end;
    end
  end

  // Shadows follow the configuration inputs throughout reset and otherwise only
  // at the frame boundary, so a frame is always processed with one setting.
  always_ff @(posedge CLK) begin
    if (!RSTb || frame_end) begin
      phase_inc_s <= phase_inc;
      gain_s      <= gain;
    end
  end

  cic_chain u_cic_i (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .sample_pos (mix_i_pos),
    .dump       (frame_end),
    .gain       (gain_s),
    .result     (out_i)
  );

  cic_chain u_cic_q (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .sample_pos (mix_q_pos),
    .dump       (frame_end),
    .gain       (gain_s),
    .result     (out_q)
  );

endmodule

// File: tb/tb_ddc_cic.sv
// tb_ddc_cic -- directed self-checking bench for ddc_cic.
//
// Expected values are hand-derived from the CIC response. For a constant +1
// input the last integrator after k samples is k(k+1)(k+2)/6, so the first
// three dumps give comb outputs 45760, 220480 and then the steady 64^3 = 262144.
// With gain 0 (shift 12) these become 11, 53, 64.
module tb_ddc_cic;

  logic              CLK       = 1'b0;
  logic              RSTb      = 1'b0;
  logic              rf_in     = 1'b0;
  logic [19:0]       phase_inc = '0;
  logic [2:0]        gain      = '0;
  logic signed [7:0] out_i;
  logic signed [7:0] out_q;
  logic              out_valid;

  int checks   = 0;
  int failures = 0;

  ddc_cic dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .rf_in     (rf_in),
    .phase_inc (phase_inc),
    .gain      (gain),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Hold reset for two cycles with the given configuration, check the cleared
  // outputs, then release.
  task automatic start(input logic rf, input logic [19:0] ph, input logic [2:0] g);
    rf_in     = rf;
    phase_inc = ph;
    gain      = g;
    RSTb      = 1'b0;
    tick(2);
    check("rst_valid", int'(out_valid), 0);
    check("rst_i", int'(out_i), 0);
    check("rst_q", int'(out_q), 0);
    RSTb = 1'b1;
  endtask

  // Wait (bounded) for the next strobe and check the number of edges it took.
  task automatic next_strobe(input string tag, input int exp_gap);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!out_valid && n < 200);
    check({tag, "_gap"}, n, exp_gap);
  endtask

  task automatic expect_strobe(input string tag, input int exp_gap,
                               input int exp_i, input int exp_q);
    next_strobe(tag, exp_gap);
    check({tag, "_i"}, int'(out_i), exp_i);
    check({tag, "_q"}, int'(out_q), exp_q);
  endtask

  initial begin
    // DC LO, rf = +1: fill-up values 11, 53, then 64 steady. The first strobe
    // arrives 64 edges after release (the 65th cycle counting the release cycle).
    start(1'b1, 20'h0, 3'd0);
    expect_strobe("dc_pos_s1", 64, 11, 11);
    expect_strobe("dc_pos_s2", 64, 53, 53);
    expect_strobe("dc_pos_s3", 64, 64, 64);
    expect_strobe("dc_pos_s4", 64, 64, 64);
    tick(1);
    check("strobe_width", int'(out_valid), 0);
    tick(30);
    check("hold_i", int'(out_i), 64);
    check("hold_q", int'(out_q), 64);
    expect_strobe("dc_pos_s5", 33, 64, 64);

    // DC LO, rf = -1: -64 steady; a mid-frame gain change to 2 leaves the next
    // strobe alone and saturates the one after (-256 -> -128).
    start(1'b0, 20'h0, 3'd0);
    for (int s = 0; s < 3; s++) next_strobe("dc_neg_fill", 64);
    expect_strobe("dc_neg_s4", 64, -64, -64);
    tick(5);
    gain = 3'd2;
    expect_strobe("gain_old", 59, -64, -64);
    expect_strobe("gain_new", 64, -128, -128);

    // Quarter-rate LO: 16 periods per frame, zero-mean on both arms.
    start(1'b1, 20'h40000, 3'd0);
    for (int s = 0; s < 3; s++) next_strobe("qrate_fill", 64);
    expect_strobe("qrate_s4", 64, 0, 0);
    expect_strobe("qrate_s5", 64, 0, 0);

    // Mid-frame tuning change at cnt == 10: frame 4 is still pure DC (64);
    // frame 5 alternates +1/-1 giving (262144 - 44704) >> 12 = 53; once three
    // whole frames are alternating the output is 0.
    start(1'b1, 20'h0, 3'd0);
    for (int s = 0; s < 3; s++) next_strobe("tune_fill", 64);
    tick(10);
    phase_inc = 20'h80000;
    expect_strobe("tune_s4", 54, 64, 64);
    expect_strobe("tune_s5", 64, 53, 53);
    next_strobe("tune_s6", 64);
    expect_strobe("tune_s7", 64, 0, 0);
    expect_strobe("tune_s8", 64, 0, 0);

    // Reset at cnt == 30 for three cycles: outputs cleared, frame aborted,
    // first strobe after release carries the partial-fill value 11.
    phase_inc = 20'h0;
    start(1'b1, 20'h0, 3'd0);
    for (int s = 0; s < 3; s++) next_strobe("mid_rst_fill", 64);
    expect_strobe("mid_rst_s4", 64, 64, 64);
    tick(30);
    RSTb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_i", int'(out_i), 0);
      check("mid_rst_q", int'(out_q), 0);
    end
    RSTb = 1'b1;
    expect_strobe("post_rst_s1", 64, 11, 11);

    // Maximum gain (shift 5): every frame saturates to +127, spacing 64.
    start(1'b1, 20'h0, 3'd7);
    for (int s = 0; s < 10; s++) expect_strobe("gain7", 64, 127, 127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ddc_cic.md
DDC_CIC -- requirements
Module: ddc_cic

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, named CLK and RSTb.
REQ-002 Port CLK  input  1  system clock; one RF sample is taken per rising edge.
REQ-003 Port RSTb  input  1  reset, synchronous and active-low.
REQ-004 Port rf_in  input  1  1-bit RF sample from the comparator; 1 = +1, 0 = -1.
REQ-005 Port phase_inc  input  20  NCO tuning word, driven by the SPI configuration block.
REQ-006 Port gain  input  3  output gain select, driven by the SPI configuration block.
REQ-007 Port out_i  output  8  signed in-phase baseband sample.
REQ-008 Port out_q  output  8  signed quadrature baseband sample.
REQ-009 Port out_valid  output  1  single-cycle strobe; out_i and out_q are valid while it is high.

Function
REQ-010 The NCO SHALL be a 20-bit accumulator acc, incremented by phase_inc_s every cycle, wrapping modulo 2^20.
REQ-011 The LO sign bits SHALL be: lo_i_neg = acc[19] XOR acc[18]; lo_q_neg = acc[19].
REQ-012 The mixer output SHALL be +1 when rf_in XNOR (NOT lo_neg) is true, and -1 otherwise, computed separately for I and Q.
REQ-013 Each channel SHALL feed a 3-stage CIC filter: 3 cascaded 20-bit two's-complement integrators running every cycle, with wrap-around permitted.
REQ-014 Decimation SHALL be R=64 with differential delay 1, driven by a 6-bit decimation counter cnt that runs 0..63 and then wraps.
REQ-015 In the cycle with cnt==63, the last integrator output, including that cycle's sample, SHALL be passed to 3 cascaded 20-bit comb stages, each with one stored delay word per stage.
REQ-016 The comb result SHALL be arithmetically shifted right by (12 - gain_s).
REQ-017 The shifted result SHALL be saturated to the range [-128, 127], then registered to out_i and out_q.
REQ-018 out_valid SHALL go high for exactly one cycle: the cycle after the cnt==63 cycle. Its period SHALL be 64 cycles.
REQ-019 out_i and out_q SHALL hold their values between strobes.
REQ-020 phase_inc_s and gain_s SHALL be shadow registers, loaded from phase_inc and gain only in the cnt==63 cycle.
REQ-021 A change on phase_inc or gain in the middle of a frame SHALL have no effect until the next frame boundary.
REQ-022 If phase_inc changes in the same cycle as cnt==63, the new value SHALL be captured and used from the next cycle.
REQ-023 phase_inc = 0 SHALL be legal: acc stays constant and the LO is DC.
REQ-024 No input handshake SHALL exist, and no backpressure SHALL exist on the outputs.

Reset
REQ-025 While RSTb is low, the following SHALL be cleared to 0: acc, cnt, all integrators, all comb delays, out_i, out_q and out_valid.
REQ-026 While RSTb is low, phase_inc_s and gain_s SHALL load phase_inc and gain every cycle, so they track the SPI defaults.
REQ-027 Reset asserted mid-frame SHALL abort that frame with no out_valid pulse. The first strobe after release SHALL come 65 cycles after the first cycle with RSTb high.

Structure
REQ-028 A shared package ddc_pkg SHALL hold these constants: PHASE_W=20, GAIN_W=3, CIC_N=3, DECIM_LOG2=6, ACC_W=20, OUT_W=8, BASE_SHIFT=12.
REQ-029 ddc_pkg SHALL also hold the signed acc_t typedef.
REQ-030 A sub-module cic_chain SHALL contain the integrators, combs, shift and saturation for one channel, and SHALL be instantiated twice (I and Q).
REQ-031 The NCO, decimation counter and shadow registers SHALL live in ddc_cic.
REQ-032 The total RTL SHALL be 120-400 lines.

Verification
REQ-033 Scenario: phase_inc=0, gain=0, rf_in=1 constant -> from the 4th strobe onward, out_i=+64 and out_q=+64.
REQ-034 Scenario: phase_inc=0, gain=0, rf_in=0 constant -> out_i=-64 and out_q=-64 in steady state. Then set gain=2 -> at the following strobe's frame, out_i=-128 and out_q=-128 (saturated).
REQ-035 Scenario: phase_inc=20'h40000, rf_in=1 constant -> the LO completes 16 periods per frame, and steady-state out_i=0 and out_q=0.
REQ-036 Scenario: phase_inc=0, rf_in=1; at cnt==10, set phase_inc=20'h80000 -> acc does not change before the cycle after cnt==63, and only then starts toggling.
REQ-037 Scenario: streaming, then RSTb low for 3 cycles at cnt==30 -> no strobe, and outputs are 0 during reset. The first strobe comes exactly 65 cycles after release and carries a partial-fill value.
REQ-038 Scenario: gain=7, rf_in=1, phase_inc=0 -> out_i=+127 (saturated), and out_valid spacing is exactly 64 cycles over 10 frames.
